// File: rtl/icache_intc_rr_scheduler.sv
// N-to-1 round-robin request scheduler with a single registered output slot.
// Fetch masters compete for one cache-bank request port. The winner of the
// round-robin search is granted combinationally and its address/UID are
// captured into the output slot, which holds them until the bank grants.
// A drain and a new capture can happen in the same cycle, so the slot
// sustains one request per cycle.
module icache_intc_rr_scheduler #(
   parameter int N_MASTER      = 8,
   parameter int ADDRESS_WIDTH = 32,
   parameter int UID_WIDTH     = N_MASTER
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [N_MASTER-1:0]                request_i,
   input  logic [N_MASTER*ADDRESS_WIDTH-1:0]  address_i,
   output logic [N_MASTER-1:0]                grant_o,
   output logic                               request_o,
   output logic [ADDRESS_WIDTH-1:0]           address_o,
   output logic [UID_WIDTH-1:0]               UID_o,
   input  logic                               grant_i
);

   localparam int PTR_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

   typedef logic [PTR_W-1:0] ptr_t;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   slot_state_t              state_q;
   slot_state_t              state_d;
   ptr_t                     rr_ptr;
   ptr_t                     rr_ptr_next;
   ptr_t                     win_idx;
   logic                     win_found;
   logic                     can_load;
   logic                     capture;
   logic [UID_WIDTH-1:0]     win_uid;
   logic [ADDRESS_WIDTH-1:0] addr_arr [N_MASTER];

   // Candidate index for search offset `offset` from `base`, wrapping at
   // N_MASTER-1 so non-power-of-two master counts never probe a phantom index.
   function automatic ptr_t wrap_idx(input ptr_t base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= N_MASTER) begin
         sum = sum - N_MASTER;
      end
      return ptr_t'(sum);
   endfunction

   // Split the flat address bus into one word per master.
   genvar gi;
   generate
      for (gi = 0; gi < N_MASTER; gi++) begin : g_addr_split
         assign addr_arr[gi] = address_i[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end
   endgenerate

   // The slot may take a new request when it is empty or is being drained now.
   assign request_o = (state_q == SLOT_FULL);
   assign can_load  = (state_q == SLOT_EMPTY) | grant_i;
   // Grants are suppressed while reset is asserted so no master sees a
   // handshake that the slot cannot honour.
   assign capture   = win_found & can_load & ~rst;

   // Round-robin search: first requesting master at or after rr_ptr.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch;
      // a path that leaves a variable unassigned would infer a latch.
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < N_MASTER; i++) begin
         if (!win_found && request_i[wrap_idx(rr_ptr, i)]) begin
            win_found = 1'b1;
            win_idx   = wrap_idx(rr_ptr, i);
         end
      end
   end

   // One-hot grant toward the winning master and one-hot UID of the winner.
   always_comb begin
      grant_o = '0;
      win_uid = '0;
      win_uid[win_idx] = 1'b1;
      if (capture) begin
         grant_o[win_idx] = 1'b1;
      end
   end

   // Pointer moves to the master after the winner, wrapping at N_MASTER-1.
   always_comb begin
      rr_ptr_next = rr_ptr;
      if (capture) begin
         if (win_idx == ptr_t'(N_MASTER - 1)) begin
            rr_ptr_next = '0;
         end else begin
            rr_ptr_next = win_idx + 1'b1;
         end
      end
   end

   // Slot occupancy: a capture fills it (even while draining), a bank grant
   // with no capture empties it, and grant_i is ignored while empty.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SLOT_EMPTY: begin
            if (capture) begin
               state_d = SLOT_FULL;
            end
         end
         SLOT_FULL: begin
            if (capture) begin
               state_d = SLOT_FULL;
            end else if (grant_i) begin
               state_d = SLOT_EMPTY;
            end
         end
         default: state_d = SLOT_EMPTY;
      endcase
   end

   // Slot occupancy register; reset drops any request held in the slot.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q <= SLOT_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Slot payload and round-robin pointer; they only change on a capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         address_o <= '0;
         UID_o     <= '0;
      end else begin
         rr_ptr <= rr_ptr_next;
         if (capture) begin
            address_o <= addr_arr[win_idx];
            UID_o     <= win_uid;
         end
      end
   end

endmodule

// File: tb/tb_icache_intc_rr_scheduler.sv
// Self-checking bench for icache_intc_rr_scheduler: a directed vector table on
// an 8-master instance, hand-written reset and wrap sequences (including a
// 5-master instance), and a randomized run against a small reference model.
module tb_icache_intc_rr_scheduler;

   localparam int N  = 8;
   localparam int N5 = 5;
   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            rst;

   // 8-master instance
   logic [N-1:0]    request_i;
   logic [N*AW-1:0] address_i;
   logic [N-1:0]    grant_o;
   logic            request_o;
   logic [AW-1:0]   address_o;
   logic [N-1:0]    uid_o;
   logic            grant_i;

   // 5-master instance
   logic [N5-1:0]    req5;
   logic [N5*AW-1:0] addr5;
   logic [N5-1:0]    grant5;
   logic             req_o5;
   logic [AW-1:0]    addr_o5;
   logic [N5-1:0]    uid5;
   logic             gnt5;

   icache_intc_rr_scheduler #(.N_MASTER(N), .ADDRESS_WIDTH(AW), .UID_WIDTH(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .request_i (request_i),
      .address_i (address_i),
      .grant_o   (grant_o),
      .request_o (request_o),
      .address_o (address_o),
      .UID_o     (uid_o),
      .grant_i   (grant_i)
   );

   icache_intc_rr_scheduler #(.N_MASTER(N5), .ADDRESS_WIDTH(AW), .UID_WIDTH(N5)) dut5 (
      .clk       (clk),
      .rst       (rst),
      .request_i (req5),
      .address_i (addr5),
      .grant_o   (grant5),
      .request_o (req_o5),
      .address_o (addr_o5),
      .UID_o     (uid5),
      .grant_i   (gnt5)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [N-1:0]  req;
      logic          gnt;
      logic [N-1:0]  exp_grant;
      logic          exp_req;
      logic [AW-1:0] exp_addr;
      logic [N-1:0]  exp_uid;
      logic [2:0]    exp_ptr;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_vec(input logic [N-1:0] req, input logic gnt,
                                   input logic [N-1:0] eg, input logic er,
                                   input logic [AW-1:0] ea, input logic [N-1:0] eu,
                                   input logic [2:0] ep);
      vec_t v;
      v.req = req; v.gnt = gnt; v.exp_grant = eg; v.exp_req = er;
      v.exp_addr = ea; v.exp_uid = eu; v.exp_ptr = ep;
      vecs.push_back(v);
   endfunction

   // One cycle on the 5-master instance; entered at posedge+1.
   task automatic step5(input logic [N5-1:0] req, input logic g, input logic [N5-1:0] eg,
                        input logic [2:0] ep, input logic [N5-1:0] eu, input logic er);
      req5 = req;
      gnt5 = g;
      #3;
      check("n5 grant_o", 64'(grant5), 64'(eg));
      @(posedge clk); #1;
      check("n5 rr_ptr", 64'(dut5.rr_ptr), 64'(ep));
      check("n5 UID_o", 64'(uid5), 64'(eu));
      check("n5 request_o", 64'(req_o5), 64'(er));
   endtask

   // Winner of a round-robin search in the reference model, -1 if none.
   function automatic int model_winner(input logic [N-1:0] req, input int ptr);
      int w;
      w = -1;
      for (int i = 0; i < N; i++) begin
         if (w < 0 && req[(ptr + i) % N]) w = (ptr + i) % N;
      end
      return w;
   endfunction

   logic          m_valid;
   logic [AW-1:0] m_addr;
   logic [N-1:0]  m_uid;
   int            m_ptr;
   int            wait_loads [N];
   logic [N-1:0]  exp_g;
   logic [N-1:0]  g_act;
   int            w;

   initial begin
      rst       = 1'b1;
      request_i = '0;
      grant_i   = 1'b0;
      req5      = '0;
      gnt5      = 1'b0;
      for (int k = 0; k < N; k++) address_i[k*AW +: AW] = 32'h100 + 32'(k * 16);
      for (int k = 0; k < N5; k++) addr5[k*AW +: AW] = 32'h500 + 32'(k * 16);

      //       req    g  grant  rq addr       uid    ptr
      add_vec(8'h00, 0, 8'h00, 0, 32'h000, 8'h00, 3'd0);
      add_vec(8'h01, 1, 8'h01, 1, 32'h100, 8'h01, 3'd1);
      add_vec(8'h01, 0, 8'h00, 1, 32'h100, 8'h01, 3'd1);
      add_vec(8'h00, 1, 8'h00, 0, 32'h100, 8'h01, 3'd1);
      add_vec(8'hFF, 0, 8'h02, 1, 32'h110, 8'h02, 3'd2);
      add_vec(8'hFF, 1, 8'h04, 1, 32'h120, 8'h04, 3'd3);
      add_vec(8'hFF, 1, 8'h08, 1, 32'h130, 8'h08, 3'd4);
      add_vec(8'hFF, 1, 8'h10, 1, 32'h140, 8'h10, 3'd5);
      add_vec(8'hFF, 1, 8'h20, 1, 32'h150, 8'h20, 3'd6);
      add_vec(8'hFF, 1, 8'h40, 1, 32'h160, 8'h40, 3'd7);
      add_vec(8'hFF, 1, 8'h80, 1, 32'h170, 8'h80, 3'd0);
      add_vec(8'hFF, 1, 8'h01, 1, 32'h100, 8'h01, 3'd1);
      add_vec(8'hFF, 1, 8'h02, 1, 32'h110, 8'h02, 3'd2);
      for (int i = 0; i < 5; i++) add_vec(8'h11, 0, 8'h00, 1, 32'h110, 8'h02, 3'd2);
      add_vec(8'h11, 1, 8'h10, 1, 32'h140, 8'h10, 3'd5);
      add_vec(8'h11, 1, 8'h01, 1, 32'h100, 8'h01, 3'd1);
      add_vec(8'h00, 1, 8'h00, 0, 32'h100, 8'h01, 3'd1);
      add_vec(8'h00, 1, 8'h00, 0, 32'h100, 8'h01, 3'd1);
      add_vec(8'h80, 0, 8'h80, 1, 32'h170, 8'h80, 3'd0);
      add_vec(8'h80, 0, 8'h00, 1, 32'h170, 8'h80, 3'd0);
      add_vec(8'h00, 1, 8'h00, 0, 32'h170, 8'h80, 3'd0);

      // Reset state, with every master requesting
      request_i = '1;
      @(posedge clk); #1;
      check("rst grant_o", 64'(grant_o), 64'h0);
      check("rst request_o", 64'(request_o), 64'h0);
      check("rst address_o", 64'(address_o), 64'h0);
      check("rst UID_o", 64'(uid_o), 64'h0);
      check("rst rr_ptr", 64'(dut.rr_ptr), 64'h0);
      request_i = '0;
      rst = 1'b0;

      // Directed vector table
      for (int i = 0; i < vecs.size(); i++) begin
         request_i = vecs[i].req;
         grant_i   = vecs[i].gnt;
         #3;
         check($sformatf("v%0d grant_o", i), 64'(grant_o), 64'(vecs[i].exp_grant));
         @(posedge clk); #1;
         check($sformatf("v%0d request_o", i), 64'(request_o), 64'(vecs[i].exp_req));
         check($sformatf("v%0d address_o", i), 64'(address_o), 64'(vecs[i].exp_addr));
         check($sformatf("v%0d UID_o", i), 64'(uid_o), 64'(vecs[i].exp_uid));
         check($sformatf("v%0d rr_ptr", i), 64'(dut.rr_ptr), 64'(vecs[i].exp_ptr));
      end

      // Mid-cycle async reset with the slot full
      request_i = 8'h04;
      grant_i   = 1'b0;
      #3;
      check("ar grant_o", 64'(grant_o), 64'h04);
      @(posedge clk); #1;
      check("ar full request_o", 64'(request_o), 64'h1);
      check("ar full UID_o", 64'(uid_o), 64'h04);
      request_i = '1;
      #2;
      rst = 1'b1;
      #1;
      check("ar request_o", 64'(request_o), 64'h0);
      check("ar UID_o", 64'(uid_o), 64'h0);
      check("ar address_o", 64'(address_o), 64'h0);
      check("ar rr_ptr", 64'(dut.rr_ptr), 64'h0);
      check("ar grant_o in rst", 64'(grant_o), 64'h0);
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      check("ar post grant_o", 64'(grant_o), 64'h01);
      @(posedge clk); #1;
      check("ar post request_o", 64'(request_o), 64'h1);
      check("ar post UID_o", 64'(uid_o), 64'h01);
      check("ar post address_o", 64'(address_o), 64'h100);
      check("ar post rr_ptr", 64'(dut.rr_ptr), 64'h1);

      // Five masters: wrap at N_MASTER-1
      //    req    g  grant  ptr   uid    rq
      step5(5'h08, 1, 5'h08, 3'd4, 5'h08, 1);
      step5(5'h00, 1, 5'h00, 3'd4, 5'h08, 0);
      step5(5'h01, 0, 5'h01, 3'd1, 5'h01, 1);
      step5(5'h08, 1, 5'h08, 3'd4, 5'h08, 1);
      step5(5'h10, 1, 5'h10, 3'd0, 5'h10, 1);
      step5(5'h11, 1, 5'h01, 3'd1, 5'h01, 1);
      check("n5 address_o", 64'(addr_o5), 64'h500);
      req5 = '0;
      gnt5 = 1'b0;

      // Randomized run against the reference model
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_valid = 1'b0;
      m_addr  = '0;
      m_uid   = '0;
      m_ptr   = 0;
      for (int k = 0; k < N; k++) wait_loads[k] = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int k = 0; k < N; k++) begin
            address_i[k*AW +: AW] = $urandom;
            request_i[k] = ($urandom_range(0, 9) < 7);
         end
         grant_i = ($urandom_range(0, 3) != 0);
         w = model_winner(request_i, m_ptr);
         exp_g = '0;
         if (w >= 0 && (!m_valid || grant_i)) exp_g[w] = 1'b1;
         #3;
         g_act = grant_o;
         check("rnd grant_o", 64'(g_act), 64'(exp_g));
         @(posedge clk); #1;
         for (int k = 0; k < N; k++) begin
            if (!request_i[k]) begin
               wait_loads[k] = 0;
            end else if (g_act != '0) begin
               if (g_act[k]) begin
                  check("rnd fairness", 64'(wait_loads[k] < N), 64'h1);
                  wait_loads[k] = 0;
               end else begin
                  wait_loads[k]++;
               end
            end
         end
         if (exp_g != '0) begin
            m_valid = 1'b1;
            m_addr  = address_i[w*AW +: AW];
            m_uid   = '0;
            m_uid[w] = 1'b1;
            m_ptr   = (w == N - 1) ? 0 : w + 1;
         end else if (m_valid && grant_i) begin
            m_valid = 1'b0;
         end
         check("rnd request_o", 64'(request_o), 64'(m_valid));
         check("rnd address_o", 64'(address_o), 64'(m_addr));
         check("rnd UID_o", 64'(uid_o), 64'(m_uid));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
